// File: rtl/bru_issue_arb.sv
// bru_issue_arb: picks the older (ROB-age) of two branch issue slots onto the BRU port; ties go round-robin.
// Latency: 1 cycle through the hold register (0 when BRU_ARB_BYPASS_EN is defined and the register is empty).
// Backpressure: readies drop while the held uop is blocked by bru_full_i, during flush_i and during reset.
module bru_issue_arb #(
    parameter int XLEN   = 64,
    parameter int ITAG_W = 8,
    parameter int UOP_W  = 3*XLEN + 20 + 5 + 10 + ITAG_W
) (
    input  logic              clk_i,
    input  logic              rstn_i,
    input  logic              flush_i,
    input  logic [ITAG_W-1:0] rob_head_i,
    input  logic              req0_valid_i,
    input  logic [UOP_W-1:0]  req0_uop_i,
    output logic              req0_ready_o,
    input  logic              req1_valid_i,
    input  logic [UOP_W-1:0]  req1_uop_i,
    output logic              req1_ready_o,
    output logic              bru_valid_o,
    output logic [UOP_W-1:0]  bru_uop_o,
    input  logic              bru_full_i
);

    logic              hold_vld;
    logic [UOP_W-1:0]  hold_uop;
    logic              rr_ptr;

    logic [ITAG_W-1:0] age0;
    logic [ITAG_W-1:0] age1;
    logic              any_req;
    logic              both_req;
    logic              tie;
    logic              win_sel;
    logic [UOP_W-1:0]  win_uop;
    logic              retire;
    logic              can_load;
    logic              accept;
    logic              byp_vld;

    // Age relative to the ROB head; modular subtraction handles tag wrap.
    assign age0     = req0_uop_i[ITAG_W-1:0] - rob_head_i;
    assign age1     = req1_uop_i[ITAG_W-1:0] - rob_head_i;
    assign any_req  = req0_valid_i | req1_valid_i;
    assign both_req = req0_valid_i & req1_valid_i;

    always_comb begin
        tie     = 1'b0;
        win_sel = req1_valid_i;
        if (both_req) begin
            if (age0 == age1) begin
                tie     = 1'b1;
                win_sel = rr_ptr;
            end else begin
                win_sel = (age1 < age0);
            end
        end
    end

    assign win_uop = win_sel ? req1_uop_i : req0_uop_i;

    // Outputs are gated with rstn_i so nothing handshakes while reset is asserted.
    assign retire   = rstn_i & hold_vld & ~bru_full_i & ~flush_i;
    assign can_load = ~hold_vld | retire;
    assign accept   = rstn_i & any_req & can_load & ~flush_i;

`ifdef BRU_ARB_BYPASS_EN
    assign byp_vld   = accept & ~hold_vld & ~bru_full_i;
    assign bru_uop_o = hold_vld ? hold_uop : win_uop;
`else
    assign byp_vld   = 1'b0;
    assign bru_uop_o = hold_uop;
`endif

    assign bru_valid_o  = retire | byp_vld;
    assign req0_ready_o = accept & ~win_sel;
    assign req1_ready_o = accept &  win_sel;

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            hold_vld <= 1'b0;
            rr_ptr   <= 1'b0;
        end else if (flush_i) begin
            hold_vld <= 1'b0;
        end else begin
            if (accept && !byp_vld) begin
                hold_vld <= 1'b1;
            end else if (retire) begin
                hold_vld <= 1'b0;
            end
            if (accept && tie) begin
                rr_ptr <= ~win_sel;
            end
        end
    end

    // Payload register carries no reset; hold_vld qualifies it.
    always_ff @(posedge clk_i) begin
        if (accept && !byp_vld) begin
            hold_uop <= win_uop;
        end
    end

endmodule

// File: tb/tb_bru_issue_arb.sv
// Bench for bru_issue_arb: directed scenarios followed by random traffic against a queue-based model.
module tb_bru_issue_arb;

    localparam int UOP_W = 3*64 + 20 + 5 + 10 + 8;

    logic             clk = 1'b0;
    logic             rstn;
    logic             flush;
    logic [7:0]       rob_head;
    logic             v0;
    logic [UOP_W-1:0] u0;
    logic             r0;
    logic             v1;
    logic [UOP_W-1:0] u1;
    logic             r1;
    logic             bvld;
    logic [UOP_W-1:0] buop;
    logic             full;

    int n_total = 0;
    int n_pass  = 0;

    // Reference state: the pending uop queue (at most one entry) and the tie pointer.
    logic [UOP_W-1:0] hold_q[$];
    bit               m_rr;
    bit               m_acc0;
    bit               m_acc1;

    logic             obs_v;
    logic             obs_r0;
    logic             obs_r1;
    logic [UOP_W-1:0] obs_uop;

    logic [UOP_W-1:0] held_uop;
    logic [UOP_W-1:0] next_uop;

    always #5 clk = ~clk;

    bru_issue_arb dut (
        .clk_i        (clk),
        .rstn_i       (rstn),
        .flush_i      (flush),
        .rob_head_i   (rob_head),
        .req0_valid_i (v0),
        .req0_uop_i   (u0),
        .req0_ready_o (r0),
        .req1_valid_i (v1),
        .req1_uop_i   (u1),
        .req1_ready_o (r1),
        .bru_valid_o  (bvld),
        .bru_uop_o    (buop),
        .bru_full_i   (full)
    );

    function automatic logic [UOP_W-1:0] mk(input logic [7:0] tag);
        logic [UOP_W-1:0] u;
        u = '0;
        repeat (8) u = (u << 32) | UOP_W'($urandom);
        u[7:0] = tag;
        return u;
    endfunction

    function automatic int age_of(input logic [UOP_W-1:0] u, input logic [7:0] head);
        return (int'(u[7:0]) - int'(head) + 256) % 256;
    endfunction

    task automatic chk(input string tag, input logic [UOP_W-1:0] obs, input logic [UOP_W-1:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // One clock: predict, sample mid-cycle, compare, then advance the model at the edge.
    task automatic step();
        bit               has, w, tie, ret, free, acc, byp, exp_v;
        int               a0, a1;
        logic [UOP_W-1:0] wu, exp_uop;
        has = v0 || v1;
        tie = 1'b0;
        w   = 1'b0;
        if (v1 && !v0) begin
            w = 1'b1;
        end else if (v0 && v1) begin
            a0  = age_of(u0, rob_head);
            a1  = age_of(u1, rob_head);
            tie = (a0 == a1);
            w   = tie ? m_rr : (a1 < a0);
        end
        wu   = w ? u1 : u0;
        ret  = rstn && hold_q.size() > 0 && !full && !flush;
        free = hold_q.size() == 0 || ret;
        acc  = rstn && has && free && !flush;
        byp  = 1'b0;
`ifdef BRU_ARB_BYPASS_EN
        byp  = acc && hold_q.size() == 0 && !full;
`endif
        exp_v   = ret || byp;
        exp_uop = ret ? hold_q[0] : wu;
        m_acc0  = acc && !w;
        m_acc1  = acc && w;

        #3;
        obs_v   = bvld;
        obs_r0  = r0;
        obs_r1  = r1;
        obs_uop = buop;
        chk("bru_valid", UOP_W'(obs_v), UOP_W'(exp_v));
        chk("req0_ready", UOP_W'(obs_r0), UOP_W'(m_acc0));
        chk("req1_ready", UOP_W'(obs_r1), UOP_W'(m_acc1));
        if (exp_v) chk("bru_uop", obs_uop, exp_uop);

        @(posedge clk);
        if (!rstn) begin
            hold_q.delete();
            m_rr = 1'b0;
        end else if (flush) begin
            hold_q.delete();
        end else begin
            if (ret) void'(hold_q.pop_front());
            if (acc && !byp) hold_q.push_back(wu);
            if (acc && tie) m_rr = !w;
        end
        #1;
    endtask

    initial begin
        rstn     = 1'b0;
        flush    = 1'b0;
        full     = 1'b0;
        rob_head = 8'h00;
        v0       = 1'b1;
        u0       = mk(8'h05);
        v1       = 1'b0;
        u1       = mk(8'h00);

        // Reset holds everything quiet even with a request pending.
        repeat (3) begin
            step();
            chk("rst_valid", UOP_W'(obs_v), '0);
            chk("rst_ready0", UOP_W'(obs_r0), '0);
        end
        rstn = 1'b1;
        step();
        chk("t1_ready0", UOP_W'(obs_r0), UOP_W'(1));
`ifdef BRU_ARB_BYPASS_EN
        chk("t1_byp_valid", UOP_W'(obs_v), UOP_W'(1));
`else
        chk("t1_valid_T", UOP_W'(obs_v), '0);
`endif
        v0 = 1'b0;
        step();
`ifndef BRU_ARB_BYPASS_EN
        chk("t1_valid_T1", UOP_W'(obs_v), UOP_W'(1));
        chk("t1_tag", UOP_W'(obs_uop[7:0]), UOP_W'(8'h05));
`endif
        step();

        // Oldest by wrapped age wins: head 0xFE, tag 0x00 (age 2) beats tag 0x03 (age 5).
        rob_head = 8'hFE;
        v0 = 1'b1; u0 = mk(8'h03);
        v1 = 1'b1; u1 = mk(8'h00);
        step();
        chk("t2_ready1", UOP_W'(obs_r1), UOP_W'(1));
        chk("t2_ready0", UOP_W'(obs_r0), '0);
        v1 = 1'b0;
        step();
        chk("t2_next0", UOP_W'(obs_r0), UOP_W'(1));
        v0 = 1'b0;
        step();
        step();

        // Equal ages alternate starting from slot 0 after reset.
        rstn = 1'b0;
        step();
        rstn = 1'b1;
        rob_head = 8'h00;
        v0 = 1'b1; u0 = mk(8'h07);
        v1 = 1'b1; u1 = mk(8'h07);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("t3_rr_slot0", UOP_W'(obs_r0), UOP_W'((i % 2) == 0));
            chk("t3_rr_slot1", UOP_W'(obs_r1), UOP_W'((i % 2) == 1));
            if (obs_r0) u0 = mk(8'h07);
            if (obs_r1) u1 = mk(8'h07);
        end
        v0 = 1'b0; v1 = 1'b0;
        step();
        step();

        // Full stalls the held uop; release retires it and accepts the next in the same cycle.
        full = 1'b1;
        v0 = 1'b1; u0 = mk(8'h20);
        held_uop = u0;
        step();
        chk("t4_load", UOP_W'(obs_r0), UOP_W'(1));
        u0 = mk(8'h21);
        next_uop = u0;
        repeat (5) begin
            step();
            chk("t4_full_valid", UOP_W'(obs_v), '0);
            chk("t4_full_ready", UOP_W'(obs_r0), '0);
            chk("t4_full_uop", obs_uop, held_uop);
        end
        full = 1'b0;
        step();
        chk("t4_rel_valid", UOP_W'(obs_v), UOP_W'(1));
        chk("t4_rel_uop", obs_uop, held_uop);
        chk("t4_rel_ready", UOP_W'(obs_r0), UOP_W'(1));
        v0 = 1'b0;
        step();
        chk("t4_next_valid", UOP_W'(obs_v), UOP_W'(1));
        chk("t4_next_uop", obs_uop, next_uop);
        step();
        chk("t4_no_dup", UOP_W'(obs_v), '0);

        // Flush drops the held uop and blocks accept for that cycle.
        full = 1'b1;
        v0 = 1'b1; u0 = mk(8'h30);
        step();
        full = 1'b0;
        flush = 1'b1;
        u0 = mk(8'h31);
        next_uop = u0;
        step();
        chk("t5_flush_valid", UOP_W'(obs_v), '0);
        chk("t5_flush_ready", UOP_W'(obs_r0), '0);
        flush = 1'b0;
        step();
        chk("t5_fresh_ready", UOP_W'(obs_r0), UOP_W'(1));
        v0 = 1'b0;
        step();
`ifndef BRU_ARB_BYPASS_EN
        chk("t5_fresh_valid", UOP_W'(obs_v), UOP_W'(1));
        chk("t5_fresh_uop", obs_uop, next_uop);
`endif
        step();

        // Idle arbiter: bypass presents the uop immediately, otherwise one cycle later.
        v1 = 1'b1; u1 = mk(8'h10);
        next_uop = u1;
        step();
        chk("t6_ready1", UOP_W'(obs_r1), UOP_W'(1));
`ifdef BRU_ARB_BYPASS_EN
        chk("t6_byp_valid", UOP_W'(obs_v), UOP_W'(1));
        chk("t6_byp_uop", obs_uop, next_uop);
`else
        chk("t6_valid_T", UOP_W'(obs_v), '0);
`endif
        v1 = 1'b0;
        step();
`ifndef BRU_ARB_BYPASS_EN
        chk("t6_valid_T1", UOP_W'(obs_v), UOP_W'(1));
        chk("t6_uop_T1", obs_uop, next_uop);
`endif

        // Random traffic; ages kept close to the head so ties are frequent.
        for (int c = 0; c < 3000; c++) begin
            if (!v0 || m_acc0) begin
                v0 = ($urandom_range(0, 2) != 0);
                u0 = mk(rob_head + 8'($urandom_range(0, 3)));
            end
            if (!v1 || m_acc1) begin
                v1 = ($urandom_range(0, 2) != 0);
                u1 = mk(rob_head + 8'($urandom_range(0, 3)));
            end
            full  = ($urandom_range(0, 3) == 0);
            flush = ($urandom_range(0, 19) == 0);
            rstn  = ($urandom_range(0, 199) != 0);
            if ($urandom_range(0, 9) == 0) rob_head = rob_head + 8'($urandom_range(0, 2));
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
